// File: rtl/sync_counter.sv
// Enable-gated modulo up-counter with terminal-count and wrap indications.
// Latency: q updates one clock after a sampled enable; tc is combinational, wrap is registered.
// No backpressure: enable=0 simply holds the count; there is no handshake.
module sync_counter #(
  parameter int          WIDTH     = 4,
  parameter int unsigned MAX_COUNT = 2**WIDTH - 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             wrap
);

  // Terminal value and increment constant held at the counter width.
  localparam logic [WIDTH-1:0] MAX_Q = MAX_COUNT[WIDTH-1:0];
  localparam logic [WIDTH-1:0] ONE_Q = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] count_q, count_d;
  logic             wrap_q,  wrap_d;

  // Next-state: advance on enable, fold to 0 at or beyond the terminal value.
  // Using >= rather than == means a corrupted out-of-range count recovers
  // on the next enabled edge instead of running on through the unused codes.
  always_comb begin
    count_d = count_q;
    wrap_d  = 1'b0;
    if (enable) begin
      if (count_q >= MAX_Q) begin
        count_d = '0;
        wrap_d  = 1'b1;
      end else begin
        count_d = count_q + ONE_Q;
      end
    end
  end

  // Count and wrap registers; synchronous reset overrides enable.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
      wrap_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      wrap_q  <= wrap_d;
    end
  end

  assign q    = count_q;
  assign wrap = wrap_q;
  // tc looks at the live enable so a cascaded stage can use it as its own enable.
  assign tc   = (count_q == MAX_Q) && enable;

endmodule

// File: tb/tb_sync_counter.sv
module tb_sync_counter;

  typedef struct packed {
    logic [3:0] q;
    logic       wrap;
  } exp_t;

  logic       clk;
  logic       reset;
  logic       enable;
  logic [3:0] q_a, q_b;
  logic       tc_a, tc_b;
  logic       wrap_a, wrap_b;

  int checks = 0;
  int errors = 0;

  // Reference models (one per DUT) and scoreboards.
  int unsigned max_cnt [2] = '{15, 9};
  int unsigned mdl_q   [2];
  bit          mdl_ok  = 0;
  int          wrap_seen_b = 0;
  exp_t        sbq_a[$];
  exp_t        sbq_b[$];

  sync_counter #(.WIDTH(4)) dut_a (
    .clk(clk), .reset(reset), .enable(enable),
    .q(q_a), .tc(tc_a), .wrap(wrap_a)
  );

  sync_counter #(.WIDTH(4), .MAX_COUNT(9)) dut_b (
    .clk(clk), .reset(reset), .enable(enable),
    .q(q_b), .tc(tc_b), .wrap(wrap_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock of stimulus: check tc before the edge, push the model's
  // prediction, then pop and compare once the edge has happened.
  task automatic step(input logic rst, input logic en);
    exp_t e;
    exp_t got;
    reset  = rst;
    enable = en;
    #1;
    if (mdl_ok) begin
      chk("tc_a", {31'b0, tc_a}, {31'b0, (mdl_q[0] == max_cnt[0]) && en});
      chk("tc_b", {31'b0, tc_b}, {31'b0, (mdl_q[1] == max_cnt[1]) && en});
    end
    for (int d = 0; d < 2; d++) begin
      e.wrap = 1'b0;
      if (rst) begin
        mdl_q[d] = 0;
      end else if (en) begin
        if (mdl_q[d] >= max_cnt[d]) begin
          mdl_q[d] = 0;
          e.wrap   = 1'b1;
        end else begin
          mdl_q[d] = mdl_q[d] + 1;
        end
      end
      e.q = mdl_q[d][3:0];
      if (d == 0) sbq_a.push_back(e);
      else        sbq_b.push_back(e);
    end
    if (rst) mdl_ok = 1;
    @(posedge clk);
    #1;
    if (sbq_a.size() == 0 || sbq_b.size() == 0) begin
      chk("sb_empty", 32'd1, 32'd0);
    end else begin
      got = sbq_a.pop_front();
      chk("q_a",    {28'b0, q_a},    {28'b0, got.q});
      chk("wrap_a", {31'b0, wrap_a}, {31'b0, got.wrap});
      got = sbq_b.pop_front();
      chk("q_b",    {28'b0, q_b},    {28'b0, got.q});
      chk("wrap_b", {31'b0, wrap_b}, {31'b0, got.wrap});
      if (wrap_b) wrap_seen_b++;
    end
  endtask

  // Safety net in case the stimulus ever stalls.
  initial begin
    #200000;
    $display("FAIL watchdog: timeout reached, expected completion");
    errors++;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1);
  end

  initial begin
    reset  = 1'b1;
    enable = 1'b0;
    @(negedge clk);

    // Reset for two edges with enable low.
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    chk("reset_q_a", {28'b0, q_a}, 32'd0);
    chk("reset_tc_a", {31'b0, tc_a}, 32'd0);

    // Count run: ten enabled edges -> 10.
    for (int i = 0; i < 10; i++) step(1'b0, 1'b1);
    chk("run_q_a", {28'b0, q_a}, 32'd10);

    // Hold for four edges.
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0);
    chk("hold_q_a", {28'b0, q_a}, 32'd10);

    // Five more enabled edges -> 15; tc must be high with enable at 15.
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1);
    chk("top_q_a", {28'b0, q_a}, 32'd15);
    enable = 1'b1;
    #1;
    chk("top_tc_a", {31'b0, tc_a}, 32'd1);

    // Wrap edge then one more edge.
    step(1'b0, 1'b1);
    chk("wrap_q_a", {28'b0, q_a}, 32'd0);
    chk("wrap_pulse_a", {31'b0, wrap_a}, 32'd1);
    step(1'b0, 1'b1);
    chk("after_wrap_q_a", {28'b0, q_a}, 32'd1);
    chk("after_wrap_pulse_a", {31'b0, wrap_a}, 32'd0);

    // Climb to 7, then reset together with enable.
    for (int i = 0; i < 6; i++) step(1'b0, 1'b1);
    chk("pre_rst_q_a", {28'b0, q_a}, 32'd7);
    step(1'b1, 1'b1);
    chk("rst_pri_q_a", {28'b0, q_a}, 32'd0);
    chk("rst_pri_wrap_a", {31'b0, wrap_a}, 32'd0);
    for (int i = 0; i < 2; i++) step(1'b0, 1'b1);
    chk("resume_q_a", {28'b0, q_a}, 32'd2);

    // Modulo-10 instance: restart from 0 and run 30 edges -> 3 wraps.
    step(1'b1, 1'b0);
    wrap_seen_b = 0;
    for (int i = 0; i < 30; i++) step(1'b0, 1'b1);
    chk("mod10_wraps", wrap_seen_b, 32'd3);
    chk("mod10_q_b", {28'b0, q_b}, 32'd0);

    // Disabled input forces tc low even at the terminal value.
    for (int i = 0; i < 9; i++) step(1'b0, 1'b1);
    chk("mod10_top_q_b", {28'b0, q_b}, 32'd9);
    enable = 1'b0;
    #1;
    chk("tc_gated_b", {31'b0, tc_b}, 32'd0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    chk("mod10_wrap_q_b", {28'b0, q_b}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
